rr_onehot_arbiter: RTL and testbench

Round-robin arbiter that shares one 8-way resource between eight requesters and drives the resource's 3-bit select plus its one-hot enable vector. It sits upstream of the 3-to-8 one-hot decode stage: the arbiter picks a winner index, holds it while the owner keeps its request up, and rotates fairly. An optional hold-limit timer forcibly releases owners that hold the resource too long.

---
 rtl/rr_arb_pkg.sv | 17 +
 rtl/onehot_dec3.sv | 14 +
 rtl/rr_onehot_arbiter.sv | 114 +++++++++++
 tb/tb_rr_onehot_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared constants and types for the round-robin one-hot arbiter.
// Optional feature macro used by the arbiter: ARB_TIMEOUT_EN.
package rr_arb_pkg;

   localparam int ARB_N  = 8;
   localparam int IDX_W  = 3;
   localparam int HOLD_W = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Reset value of the round-robin pointer: index 0 gets first priority.
   localparam logic [IDX_W-1:0] LAST_RST = 3'd7;

endpackage

// File: rtl/onehot_dec3.sv
// Purely combinational 3-to-8 one-hot decoder feeding the arbiter's enable vector.
module onehot_dec3
   import rr_arb_pkg::*;
(
   input  logic [IDX_W-1:0] i_idx,
   output logic [ARB_N-1:0] o_onehot
);

   always_comb begin
      o_onehot        = '0;
      o_onehot[i_idx] = 1'b1;
   end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Eight-way round-robin arbiter driving a 3-bit select and a one-hot enable.
// Define ARB_TIMEOUT_EN to build the hold-limit timer and forced release.
module rr_onehot_arbiter
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic       gnt_valid,
   output logic [2:0] gnt_idx,
   output logic [7:0] gnt_onehot,
   output logic       timeout
);

   if (MAX_HOLD < 1 || MAX_HOLD > (1 << HOLD_W) - 1) begin : g_bad_max_hold
      $error("rr_onehot_arbiter: MAX_HOLD must be in 1..15");
   end

   // Rotate so the slot after 'last' sits at bit 0, take the lowest set bit,
   // then rotate the winner back. MSB of the result flags that a winner exists.
   function automatic logic [IDX_W:0] rr_pick(input logic [ARB_N-1:0] reqv,
                                              input logic [IDX_W-1:0] last);
      logic [IDX_W:0]   sh;
      logic [ARB_N-1:0] rot;
      logic [IDX_W:0]   res;
      sh  = {1'b0, last} + (IDX_W+1)'(1);
      rot = ARB_N'({reqv, reqv} >> sh);
      res = '0;
      for (int j = ARB_N-1; j >= 0; j--) begin
         if (rot[j]) res = {1'b1, IDX_W'(last + IDX_W'(j) + IDX_W'(1))};
      end
      return res;
   endfunction

   arb_state_t       r_state;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] r_last;

   logic             w_rel;
   logic             w_force;
   logic             w_take;
   logic [ARB_N-1:0] w_cand;
   logic [IDX_W:0]   w_pick;
   logic [ARB_N-1:0] w_dec;

`ifdef ARB_TIMEOUT_EN
   localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
   logic [HOLD_W-1:0] r_hold;
   logic              r_timeout;
`endif

   always_comb begin
      w_rel   = (r_state == GRANT) && !req[r_idx];
`ifdef ARB_TIMEOUT_EN
      // A release on the same edge wins over the timer, so no pulse then.
      w_force = (r_state == GRANT) && req[r_idx] && (r_hold == MAX_HOLD_C);
`else
      w_force = 1'b0;
`endif
      w_take  = (r_state == IDLE) || w_rel || w_force;
      w_cand  = req;
      if (w_force) w_cand[r_idx] = 1'b0;
      w_pick  = rr_pick(w_cand, r_last);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_last  <= LAST_RST;
      end else if (w_take) begin
         if (w_pick[IDX_W]) begin
            r_state <= GRANT;
            r_idx   <= w_pick[IDX_W-1:0];
            r_last  <= w_pick[IDX_W-1:0];
         end else begin
            r_state <= IDLE;
            r_idx   <= '0;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_force;
         if (w_take && w_pick[IDX_W]) begin
            r_hold <= HOLD_W'(1);
         end else if (r_state == GRANT && r_hold != MAX_HOLD_C) begin
            r_hold <= r_hold + HOLD_W'(1);
         end
      end
   end

   assign timeout = r_timeout;
`else
   assign timeout = 1'b0;
`endif

   onehot_dec3 u_dec (
      .i_idx    (r_idx),
      .o_onehot (w_dec)
   );

   assign gnt_valid  = (r_state == GRANT);
   assign gnt_idx    = r_idx;
   assign gnt_onehot = w_dec & {ARB_N{gnt_valid}};

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Scoreboard bench for rr_onehot_arbiter; timer scenarios run when ARB_TIMEOUT_EN is defined.
module tb_rr_onehot_arbiter;

   localparam int MAX_HOLD = 4;

   typedef struct {
      string       name;
      logic [12:0] exp;   // {valid, idx[2:0], onehot[7:0], timeout}
   } sb_entry_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic       gnt_valid;
   logic [2:0] gnt_idx;
   logic [7:0] gnt_onehot;
   logic       timeout;

   sb_entry_t  exp_q[$];
   int         checks   = 0;
   int         failures = 0;
   logic       done     = 1'b0;

   rr_onehot_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx),
      .gnt_onehot (gnt_onehot),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [12:0] E(input logic v, input logic [2:0] ix,
                                     input logic [7:0] oh, input logic to);
      return {v, ix, oh, to};
   endfunction

   // Drive one edge's inputs and queue the outputs expected after that edge.
   task automatic step(input string nm, input logic r, input logic [7:0] rq,
                       input logic [12:0] ex);
      sb_entry_t e;
      @(negedge clk);
      rst    = r;
      req    = rq;
      e.name = nm;
      e.exp  = ex;
      exp_q.push_back(e);
   endtask

   // Monitor: outputs are registered, so every cycle presents a response.
   initial begin
      sb_entry_t   e;
      logic [12:0] got;
      forever begin
         @(posedge clk);
         #1;
         if (done) break;
         if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {gnt_valid, gnt_idx, gnt_onehot, timeout};
            checks++;
            if (got !== e.exp) begin
               failures++;
               $display("FAIL %s: got v=%0b idx=%0d oh=%02h to=%0b, want v=%0b idx=%0d oh=%02h to=%0b",
                        e.name, got[12], got[11:9], got[8:1], got[0],
                        e.exp[12], e.exp[11:9], e.exp[8:1], e.exp[0]);
            end
            checks++;
            if (!$onehot0(gnt_onehot)) begin
               failures++;
               $display("FAIL %s_onehot0: got oh=%02h, want at most one bit set",
                        e.name, gnt_onehot);
            end
         end
      end
   end

   initial begin
      // Reset and idle
      step("rst",      1'b1, 8'h00, E(0, 3'd0, 8'h00, 0));
      for (int i = 0; i < 5; i++)
         step("idle",  1'b0, 8'h00, E(0, 3'd0, 8'h00, 0));

      // Two requesters alternate with no bubble
      step("alt_rst",  1'b1, 8'h81, E(0, 3'd0, 8'h00, 0));
      step("alt_g0a",  1'b0, 8'h81, E(1, 3'd0, 8'h01, 0));
      step("alt_g0b",  1'b0, 8'h81, E(1, 3'd0, 8'h01, 0));
      step("alt_g0c",  1'b0, 8'h81, E(1, 3'd0, 8'h01, 0));
      step("alt_g7a",  1'b0, 8'h80, E(1, 3'd7, 8'h80, 0));
      step("alt_g7b",  1'b0, 8'h81, E(1, 3'd7, 8'h80, 0));
      step("alt_g7c",  1'b0, 8'h81, E(1, 3'd7, 8'h80, 0));
      step("alt_g0d",  1'b0, 8'h01, E(1, 3'd0, 8'h01, 0));
      step("alt_g0e",  1'b0, 8'h81, E(1, 3'd0, 8'h01, 0));
      step("alt_g0f",  1'b0, 8'h81, E(1, 3'd0, 8'h01, 0));
      step("alt_g7d",  1'b0, 8'h80, E(1, 3'd7, 8'h80, 0));
      step("alt_g7e",  1'b0, 8'h81, E(1, 3'd7, 8'h80, 0));
      step("alt_idle", 1'b0, 8'h00, E(0, 3'd0, 8'h00, 0));

      // Rotation 2 -> 3 -> 5 -> wrap to 2
      step("rot_rst",  1'b1, 8'h00, E(0, 3'd0, 8'h00, 0));
      step("rot_g2",   1'b0, 8'h04, E(1, 3'd2, 8'h04, 0));
      step("rot_hold", 1'b0, 8'h2C, E(1, 3'd2, 8'h04, 0));
      step("rot_g3",   1'b0, 8'h28, E(1, 3'd3, 8'h08, 0));
      step("rot_nonown", 1'b0, 8'h29, E(1, 3'd3, 8'h08, 0));
      step("rot_g5",   1'b0, 8'h24, E(1, 3'd5, 8'h20, 0));
      step("rot_g5b",  1'b0, 8'h24, E(1, 3'd5, 8'h20, 0));
      step("rot_wrap2", 1'b0, 8'h04, E(1, 3'd2, 8'h04, 0));
      step("rot_idle", 1'b0, 8'h00, E(0, 3'd0, 8'h00, 0));

      // Reset mid-grant, then all requesting
      step("mid_g5",   1'b0, 8'h20, E(1, 3'd5, 8'h20, 0));
      step("mid_g5b",  1'b0, 8'h20, E(1, 3'd5, 8'h20, 0));
      step("mid_rst",  1'b1, 8'hFF, E(0, 3'd0, 8'h00, 0));
      step("mid_g0",   1'b0, 8'hFF, E(1, 3'd0, 8'h01, 0));
      step("mid_g1",   1'b0, 8'hFE, E(1, 3'd1, 8'h02, 0));
      step("mid_g2",   1'b0, 8'hFC, E(1, 3'd2, 8'h04, 0));
      step("mid_idle", 1'b0, 8'h00, E(0, 3'd0, 8'h00, 0));

`ifdef ARB_TIMEOUT_EN
      // Lone requester is forced off after MAX_HOLD cycles
      step("to1_rst",  1'b1, 8'h00, E(0, 3'd0, 8'h00, 0));
      for (int i = 0; i < MAX_HOLD; i++)
         step("to1_g4", 1'b0, 8'h10, E(1, 3'd4, 8'h10, 0));
      step("to1_pulse", 1'b0, 8'h10, E(0, 3'd0, 8'h00, 1));
      step("to1_regnt", 1'b0, 8'h10, E(1, 3'd4, 8'h10, 0));
      step("to1_idle", 1'b0, 8'h00, E(0, 3'd0, 8'h00, 0));

      // Two holders swap on each timeout
      step("to2_rst",  1'b1, 8'h00, E(0, 3'd0, 8'h00, 0));
      for (int i = 0; i < MAX_HOLD; i++)
         step("to2_g0", 1'b0, 8'h11, E(1, 3'd0, 8'h01, 0));
      step("to2_sw4",  1'b0, 8'h11, E(1, 3'd4, 8'h10, 1));
      for (int i = 1; i < MAX_HOLD; i++)
         step("to2_g4", 1'b0, 8'h11, E(1, 3'd4, 8'h10, 0));
      step("to2_sw0",  1'b0, 8'h11, E(1, 3'd0, 8'h01, 1));
      step("to2_g0b",  1'b0, 8'h11, E(1, 3'd0, 8'h01, 0));
      step("to2_idle", 1'b0, 8'h00, E(0, 3'd0, 8'h00, 0));

      // Release on the limit edge is a normal release
      step("to3_rst",  1'b1, 8'h00, E(0, 3'd0, 8'h00, 0));
      for (int i = 0; i < MAX_HOLD; i++)
         step("to3_g4", 1'b0, 8'h10, E(1, 3'd4, 8'h10, 0));
      step("to3_rel",  1'b0, 8'h00, E(0, 3'd0, 8'h00, 0));
`endif

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      end
      done = 1'b1;
      @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
